// File: rtl/writeback.sv
// writeback: final Y86-64 pipeline stage. Holds the W pipeline register,
// owns the 15x64 register file, serves the two decode read ports and
// freezes architectural state on the first non-AOK status.
// Optional feature macro: WB_BYPASS_EN (same-cycle write-to-read bypass).
module writeback #(
  parameter logic [2:0] STAT_AOK = 3'd1,
  parameter logic [2:0] STAT_ADR = 3'd2,
  parameter logic [2:0] STAT_INS = 3'd3,
  parameter logic [2:0] STAT_HLT = 3'd4,
  parameter logic [3:0] RNONE    = 4'hF,
  parameter logic [3:0] INOP     = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        W_stall,
  input  logic        W_bubble,
  input  logic [2:0]  m_stat,
  input  logic [3:0]  m_icode,
  input  logic [63:0] m_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  m_dstE,
  input  logic [3:0]  m_dstM,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] d_rvalA,
  output logic [63:0] d_rvalB,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [2:0]  stat,
  output logic        halted
);

  // W pipeline register state
  logic [2:0]  W_stat_q;
  logic [3:0]  W_icode_q;
  logic [63:0] W_valE_q;
  logic [63:0] W_valM_q;
  logic [3:0]  W_dstE_q;
  logic [3:0]  W_dstM_q;

  // Architectural state
  logic [63:0] regs_q [0:14];
  logic        halted_q;
  logic [2:0]  cap_stat_q;

  // Per-port commit enables; a halting instruction never commits itself
  logic commit_ok, commit_e, commit_m;

  assign commit_ok = (W_stat_q == STAT_AOK) && !halted_q;
  assign commit_e  = commit_ok && (W_dstE_q != RNONE);
  assign commit_m  = commit_ok && (W_dstM_q != RNONE);

  // W register: reset > stall (hold) > bubble > load from memory stage
  always_ff @(posedge clk) begin
    if (reset || (!W_stall && W_bubble)) begin
      W_stat_q  <= STAT_AOK;
      W_icode_q <= INOP;
      W_valE_q  <= 64'd0;
      W_valM_q  <= 64'd0;
      W_dstE_q  <= RNONE;
      W_dstM_q  <= RNONE;
    end else if (!W_stall) begin
      W_stat_q  <= m_stat;
      W_icode_q <= m_icode;
      W_valE_q  <= m_valE;
      W_valM_q  <= m_valM;
      W_dstE_q  <= m_dstE;
      W_dstM_q  <= m_dstM;
    end
  end

  // Register file commit; on dstE==dstM only the valM write happens
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= 64'd0;
    end else begin
      if (commit_e && !(commit_m && (W_dstM_q == W_dstE_q)))
        regs_q[W_dstE_q] <= W_valE_q;
      if (commit_m)
        regs_q[W_dstM_q] <= W_valM_q;
    end
  end

  // Sticky halt: capture the first non-AOK status reaching W
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q   <= 1'b0;
      cap_stat_q <= STAT_AOK;
    end else if (!halted_q && (W_stat_q != STAT_AOK)) begin
      halted_q   <= 1'b1;
      cap_stat_q <= W_stat_q;
    end
  end

  // Decode read ports, optionally bypassing the value committed this cycle
  always_comb begin
    d_rvalA = 64'd0;
    d_rvalB = 64'd0;
    if (srcA != RNONE) d_rvalA = regs_q[srcA];
    if (srcB != RNONE) d_rvalB = regs_q[srcB];
`ifdef WB_BYPASS_EN
    if (srcA != RNONE) begin
      if (commit_m && (srcA == W_dstM_q))      d_rvalA = W_valM_q;
      else if (commit_e && (srcA == W_dstE_q)) d_rvalA = W_valE_q;
    end
    if (srcB != RNONE) begin
      if (commit_m && (srcB == W_dstM_q))      d_rvalB = W_valM_q;
      else if (commit_e && (srcB == W_dstE_q)) d_rvalB = W_valE_q;
    end
`else
`endif
  end

  assign W_stat  = W_stat_q;
  assign W_icode = W_icode_q;
  assign W_valE  = W_valE_q;
  assign W_valM  = W_valM_q;
  assign W_dstE  = W_dstE_q;
  assign W_dstM  = W_dstM_q;
  assign halted  = halted_q;
  assign stat    = halted_q ? cap_stat_q : W_stat_q;

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for writeback.
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        W_stall, W_bubble;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE, m_valM;
  logic [3:0]  m_dstE, m_dstM;
  logic [3:0]  srcA, srcB;
  logic [63:0] d_rvalA, d_rvalB;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM;
  logic [2:0]  stat;
  logic        halted;

  int checks = 0;
  int errors = 0;

  writeback dut (
    .clk(clk), .reset(reset), .W_stall(W_stall), .W_bubble(W_bubble),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .srcA(srcA), .srcB(srcB),
    .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .stat(stat), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm);
    m_stat = st; m_icode = ic; m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm;
  endtask

  task automatic nop();
    drive(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
  endtask

  initial begin
    // Reset with every other input unknown
    reset = 1'b1; W_stall = 1'bx; W_bubble = 1'bx;
    drive('x, 'x, 'x, 'x, 'x, 'x);
    srcA = 'x; srcB = 'x;
    tick(); tick();
    reset = 1'b0; W_stall = 1'b0; W_bubble = 1'b0; nop();
    srcA = 4'h0; srcB = 4'hF;
    tick(); tick();
    check("rst_icode", W_icode, 64'h1);
    check("rst_dstE", W_dstE, 64'hF);
    check("rst_dstM", W_dstM, 64'hF);
    check("rst_stat", stat, 64'h1);
    check("rst_halted", halted, 64'h0);
    check("rst_rnone_B", d_rvalB, 64'h0);
    for (int i = 0; i < 15; i++) begin
      srcA = i[3:0];
      #1;
      check($sformatf("rst_reg%0d", i), d_rvalA, 64'h0);
    end

    // Simple valE write to r2: W after edge 1, array after edge 2
    drive(3'd1, 4'h3, 64'h5, 64'h0, 4'h2, 4'hF);
    srcA = 4'h2;
    tick();
    check("w_valE_r2", W_valE, 64'h5);
    check("w_dstE_r2", W_dstE, 64'h2);
`ifdef WB_BYPASS_EN
    check("r2_same_cycle", d_rvalA, 64'h5);
`else
    check("r2_same_cycle", d_rvalA, 64'h0);
`endif
    nop();
    tick();
    check("r2_committed", d_rvalA, 64'h5);

    // dstE == dstM: valM wins
    drive(3'd1, 4'hB, 64'h8, 64'h100, 4'h4, 4'h4);
    tick();
    nop();
    tick();
    srcB = 4'h4;
    #1;
    check("r4_valM_wins", d_rvalB, 64'h100);

    // Stall holds W while m_* changes
    drive(3'd1, 4'h3, 64'h77, 64'h0, 4'h7, 4'hF);
    tick();
    W_stall = 1'b1;
    drive(3'd1, 4'h6, 64'h88, 64'h0, 4'h8, 4'hF);
    tick();
    check("stall1_dstE", W_dstE, 64'h7);
    drive(3'd1, 4'h2, 64'h99, 64'h0, 4'h8, 4'h9);
    tick();
    check("stall2_valE", W_valE, 64'h77);
    drive(3'd1, 4'h5, 64'hAA, 64'hBB, 4'h8, 4'h9);
    tick();
    check("stall3_icode", W_icode, 64'h3);
    check("stall3_dstM", W_dstM, 64'hF);
    srcA = 4'h8; srcB = 4'h7;
    #1;
    check("stall_no_r8", d_rvalA, 64'h0);
    check("stall_r7", d_rvalB, 64'h77);

    // Bubble beats load (stall released)
    W_stall = 1'b0; W_bubble = 1'b1;
    tick();
    check("bub_icode", W_icode, 64'h1);
    check("bub_dstE", W_dstE, 64'hF);
    check("bub_dstM", W_dstM, 64'hF);
    check("bub_halted", halted, 64'h0);
    W_bubble = 1'b0; nop();
    tick();
    check("after_bub_r8", d_rvalA, 64'h0);

    // Same-cycle visibility of r6 commit
    drive(3'd1, 4'h3, 64'h7, 64'h0, 4'h6, 4'hF);
    srcA = 4'h6;
    tick();
`ifdef WB_BYPASS_EN
    check("r6_same_cycle", d_rvalA, 64'h7);
`else
    check("r6_same_cycle", d_rvalA, 64'h0);
`endif
    nop();
    tick();
    check("r6_next_cycle", d_rvalA, 64'h7);

    // Address fault freezes architectural state
    drive(3'd2, 4'h5, 64'h9, 64'h0, 4'h3, 4'hF);
    tick();
    check("adr_W_stat", W_stat, 64'h2);
    check("adr_halted_pre", halted, 64'h0);
    check("adr_stat_pre", stat, 64'h2);
    drive(3'd1, 4'h3, 64'h55, 64'h0, 4'h5, 4'hF);
    tick();
    check("adr_halted", halted, 64'h1);
    check("adr_stat", stat, 64'h2);
    check("adr_W_loads", W_dstE, 64'h5);
    nop();
    tick();
    srcA = 4'h3; srcB = 4'h5;
    #1;
    check("adr_stat_held", stat, 64'h2);
    check("adr_halted_held", halted, 64'h1);
    check("adr_no_r3", d_rvalA, 64'h0);
    check("adr_no_r5", d_rvalB, 64'h0);

    // Reset clears halt, status and the register file
    reset = 1'b1;
    tick();
    reset = 1'b0;
    srcA = 4'h2; srcB = 4'h4;
    #1;
    check("rst2_halted", halted, 64'h0);
    check("rst2_stat", stat, 64'h1);
    check("rst2_icode", W_icode, 64'h1);
    check("rst2_r2", d_rvalA, 64'h0);
    check("rst2_r4", d_rvalB, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
